pipelined_addsub: RTL and testbench

- Parametrised, pipelined successor of the fixed 32-bit ripple adder.
- Splits a WIDTH-bit add/subtract into STAGES registered carry-chain segments and accepts one operation per cycle under a valid/ready handshake.
- Reports carry, signed overflow and zero flags.
- Sits in the core datapath wherever a long carry chain would otherwise limit clock frequency, e.g. the ALU adder path or address generation.

---
 rtl/pipelined_addsub.sv | 131 +++++++++++++
 tb/tb_pipelined_addsub.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is cut into STAGES
// registered segments, with a valid/ready handshake and carry/overflow/zero flags.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    input  logic             sub_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             zero_o
);
    localparam int SEG  = WIDTH / STAGES;
    localparam int MSB  = WIDTH - 1;
    localparam int LAST = STAGES - 1;

    logic             v_q  [STAGES];
    logic             v_d  [STAGES];
    logic [WIDTH-1:0] a_q  [STAGES];
    logic [WIDTH-1:0] a_d  [STAGES];
    logic [WIDTH-1:0] b_q  [STAGES];
    logic [WIDTH-1:0] b_d  [STAGES];
    logic [WIDTH-1:0] s_q  [STAGES];
    logic [WIDTH-1:0] s_d  [STAGES];
    logic             c_q  [STAGES];
    logic             c_d  [STAGES];
    logic             zero_q;
    logic             zero_d;

    logic             v_in [STAGES];
    logic [WIDTH-1:0] a_in [STAGES];
    logic [WIDTH-1:0] b_in [STAGES];
    logic [WIDTH-1:0] s_in [STAGES];
    logic             c_in [STAGES];
    logic [STAGES-1:0] load;

    // Stage 0 takes the conditioned operands; every later stage takes its predecessor.
    always_comb begin
        v_in[0] = valid_i;
        a_in[0] = a_i;
        b_in[0] = sub_i ? ~b_i : b_i;
        s_in[0] = '0;
        c_in[0] = sub_i ? 1'b1 : carry_i;
        for (int k = 1; k < STAGES; k++) begin
            v_in[k] = v_q[k-1];
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            s_in[k] = s_q[k-1];
            c_in[k] = c_q[k-1];
        end
    end

    // A stage loads when it is empty or its successor is loading in the same cycle.
    always_comb begin
        logic nxt;
        load = '0;
        nxt  = !v_q[LAST] || ready_i;
        load[LAST] = nxt;
        for (int k = STAGES - 2; k >= 0; k--) begin
            nxt     = !v_q[k] || nxt;
            load[k] = nxt;
        end
    end

    always_comb begin
        logic [SEG:0] seg;
        seg    = '0;
        zero_d = zero_q;
        for (int k = 0; k < STAGES; k++) begin
            v_d[k] = v_q[k];
            a_d[k] = a_q[k];
            b_d[k] = b_q[k];
            s_d[k] = s_q[k];
            c_d[k] = c_q[k];
            if (load[k]) begin
                v_d[k] = v_in[k];
                // Bubbles leave the datapath untouched, so outputs keep their last value.
                if (v_in[k]) begin
                    seg = {1'b0, a_in[k][k*SEG +: SEG]} + {1'b0, b_in[k][k*SEG +: SEG]}
                        + (SEG + 1)'(c_in[k]);
                    a_d[k] = a_in[k];
                    b_d[k] = b_in[k];
                    s_d[k] = s_in[k];
                    s_d[k][k*SEG +: SEG] = seg[SEG-1:0];
                    c_d[k] = seg[SEG];
                end
            end
        end
        if (load[LAST] && v_in[LAST]) begin
            zero_d = (s_d[LAST] == '0);
        end
    end

    // NOTE: the datapath is cleared with the valid bits so every output reads 0 after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
            zero_q <= 1'b0;
        end else begin
            v_q    <= v_d;
            a_q    <= a_d;
            b_q    <= b_d;
            s_q    <= s_d;
            c_q    <= c_d;
            zero_q <= zero_d;
        end
    end

    assign ready_o    = load[0];
    assign valid_o    = v_q[LAST];
    assign sum_o      = s_q[LAST];
    assign carry_o    = c_q[LAST];
    assign zero_o     = zero_q;
    assign overflow_o = (a_q[LAST][MSB] == b_q[LAST][MSB]) && (s_q[LAST][MSB] != a_q[LAST][MSB]);

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: randomized and directed operations against an
// arithmetic reference model, plus smoke runs of the 16/1 and 64/8 configurations.
module tb_pipelined_addsub;
    localparam int S = 4;
    localparam longint SMAX = 64'sh7FFF_FFFF;
    localparam longint SMIN = -64'sh8000_0000;

    typedef struct packed {
        logic [31:0] sum;
        logic        c;
        logic        ov;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i, valid_i, ready_o, carry_i, sub_i, valid_o, ready_i;
    logic [31:0] a_i, b_i, sum_o;
    logic        carry_o, overflow_o, zero_o;

    logic        v16, ro16, vo16, co16, ov16, z16, v64, ro64, vo64, co64, ov64, z64;
    logic        xs_c, xs_s, x_rdy;
    logic [15:0] a16, b16, s16;
    logic [63:0] a64, b64, s64;

    exp_t sb_q[$];
    int   issue_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(32), .STAGES(S)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .a_i(a_i), .b_i(b_i), .carry_i(carry_i), .sub_i(sub_i),
        .valid_o(valid_o), .ready_i(ready_i), .sum_o(sum_o), .carry_o(carry_o),
        .overflow_o(overflow_o), .zero_o(zero_o)
    );

    pipelined_addsub #(.WIDTH(16), .STAGES(1)) dut16 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(v16), .ready_o(ro16),
        .a_i(a16), .b_i(b16), .carry_i(xs_c), .sub_i(xs_s),
        .valid_o(vo16), .ready_i(x_rdy), .sum_o(s16), .carry_o(co16),
        .overflow_o(ov16), .zero_o(z16)
    );

    pipelined_addsub #(.WIDTH(64), .STAGES(8)) dut64 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(v64), .ready_o(ro64),
        .a_i(a64), .b_i(b64), .carry_i(xs_c), .sub_i(xs_s),
        .valid_o(vo64), .ready_i(x_rdy), .sum_o(s64), .carry_o(co64),
        .overflow_o(ov64), .zero_o(z64)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] sum, input logic c, input logic ov, input logic z);
        exp_t e;
        e.sum = sum;
        e.c   = c;
        e.ov  = ov;
        e.z   = z;
        return e;
    endfunction

    // Reference: plain integer arithmetic; overflow means the true signed result is out of range.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        exp_t        e;
        longint      sr;
        logic [32:0] full;
        if (sub) begin
            e.sum = a - b;
            e.c   = (a >= b);
            sr    = longint'($signed(a)) - longint'($signed(b));
        end else begin
            full  = {1'b0, a} + {1'b0, b} + 33'(cin);
            e.sum = full[31:0];
            e.c   = full[32];
            sr    = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        end
        e.ov = (sr > SMAX) || (sr < SMIN);
        e.z  = (e.sum == 32'h0);
        return e;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 4))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000 | 32'($urandom_range(0, 1));
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic s, input exp_t e);
        int budget = 0;
        @(negedge clk);
        a_i = a; b_i = b; carry_i = c; sub_i = s; valid_i = 1'b1;
        forever begin
            #2;
            if (ready_o && !rst_i) begin
                sb_q.push_back(e);
                break;
            end
            budget++;
            if (budget > 200) begin
                check("send_accept_timeout", ready_o, 1);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic send_rand();
        logic [31:0] a, b;
        logic        c, s;
        a = rnd_operand();
        b = rnd_operand();
        c = 1'($urandom_range(0, 1));
        s = 1'($urandom_range(0, 1));
        send(a, b, c, s, model(a, b, c, s));
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks handshake behaviour.
    int          mon_cyc = 0, n_in = 0, last_stall = -1, t_issue;
    bit          prev_rst = 1'b1, prev_stall = 1'b0;
    logic [31:0] prev_sum;
    logic        prev_c, prev_ov, prev_z;
    exp_t        got_e;

    initial begin : monitor
        forever begin
            @(negedge clk);
            #2;
            mon_cyc++;
            if (rst_i) begin
                sb_q.delete();
                issue_q.delete();
                n_in       = 0;
                prev_rst   = 1'b1;
                prev_stall = 1'b0;
                continue;
            end
            if (prev_rst) begin
                check("reset_valid_o", valid_o, 0);
                check("reset_sum_o", sum_o, 0);
                check("reset_carry_o", carry_o, 0);
                check("reset_overflow_o", overflow_o, 0);
                check("reset_zero_o", zero_o, 0);
                check("reset_ready_o", ready_o, 1);
                prev_rst = 1'b0;
            end
            check("ready_o", ready_o, !(n_in == S && !ready_i));
            if (prev_stall) begin
                check("stall_valid_o", valid_o, 1);
                check("stall_sum_o", sum_o, prev_sum);
                check("stall_flags", {carry_o, overflow_o, zero_o}, {prev_c, prev_ov, prev_z});
            end
            if (valid_o && ready_i) begin
                if (sb_q.size() == 0) begin
                    check("spurious_valid_o", valid_o, 0);
                end else begin
                    got_e   = sb_q.pop_front();
                    t_issue = issue_q.pop_front();
                    check("sum_o", sum_o, got_e.sum);
                    check("carry_o", carry_o, got_e.c);
                    check("overflow_o", overflow_o, got_e.ov);
                    check("zero_o", zero_o, got_e.z);
                    if (last_stall < t_issue) check("latency", mon_cyc - t_issue, S);
                    n_in--;
                end
            end
            if (valid_i && ready_o) begin
                issue_q.push_back(mon_cyc);
                n_in++;
            end
            prev_stall = valid_o && !ready_i;
            if (prev_stall) last_stall = mon_cyc;
            prev_sum = sum_o;
            prev_c   = carry_o;
            prev_ov  = overflow_o;
            prev_z   = zero_o;
        end
    end

    logic [63:0] e16s[2] = '{64'h0, 64'h7FFF};
    logic [63:0] e64s[2] = '{64'h0, 64'h7FFF_FFFF_FFFF_FFFF};
    logic [2:0]  exf[2]  = '{3'b101, 3'b110};   // {carry, overflow, zero} for both configs
    int          lat16 = 0, lat64 = 0, i16 = 0, i64 = 0;

    initial begin : stimulus
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        a_i = '0; b_i = '0; carry_i = 1'b0; sub_i = 1'b0;
        v16 = 1'b0; v64 = 1'b0; a16 = '0; b16 = '0; a64 = '0; b64 = '0;
        xs_c = 1'b0; xs_s = 1'b0; x_rdy = 1'b1;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;

        send(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, mk(32'h0, 1'b1, 1'b0, 1'b1));
        idle(6);
        send(32'd5, 32'd7, 1'b1, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
        send(32'h8000_0000, 32'd1, 1'b0, 1'b1, mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
        send(32'h0FFF_FFFF, 32'd0, 1'b1, 1'b0, mk(32'h1000_0000, 1'b0, 1'b0, 1'b0));
        send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0));
        idle(6);

        for (int i = 0; i < 16; i++) send_rand();
        idle(6);

        fork
            for (int i = 0; i < 14; i++) send_rand();
            begin
                repeat (3) @(negedge clk);
                ready_i = 1'b0;
                repeat (6) @(negedge clk);
                ready_i = 1'b1;
            end
        join
        idle(10);

        for (int i = 0; i < 3; i++) send_rand();
        @(negedge clk);
        valid_i = 1'b0;
        rst_i   = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        send(32'd2, 32'd3, 1'b0, 1'b0, mk(32'd5, 1'b0, 1'b0, 1'b0));
        idle(8);

        // Smoke runs of the other configurations: one add then one overflowing subtract.
        @(negedge clk);
        v16 = 1'b1; a16 = 16'h0001; b16 = 16'hFFFF;
        v64 = 1'b1; a64 = 64'h1;    b64 = 64'hFFFF_FFFF_FFFF_FFFF;
        xs_c = 1'b0; xs_s = 1'b0;
        #2;
        check("x16_ready_o", ro16, 1);
        check("x64_ready_o", ro64, 1);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                a16 = 16'h8000; b16 = 16'h0001;
                a64 = 64'h8000_0000_0000_0000; b64 = 64'h1;
                xs_s = 1'b1;
            end else begin
                v16 = 1'b0;
                v64 = 1'b0;
            end
            #2;
            if (vo16) begin
                if (i16 < 2) begin
                    if (i16 == 0) lat16 = cyc;
                    check("x16_sum_o", s16, e16s[i16]);
                    check("x16_flags", {co16, ov16, z16}, exf[i16]);
                    i16++;
                end else check("x16_extra_valid_o", vo16, 0);
            end
            if (vo64) begin
                if (i64 < 2) begin
                    if (i64 == 0) lat64 = cyc;
                    check("x64_sum_o", s64, e64s[i64]);
                    check("x64_flags", {co64, ov64, z64}, exf[i64]);
                    i64++;
                end else check("x64_extra_valid_o", vo64, 0);
            end
        end
        check("x16_latency", lat16, 1);
        check("x64_latency", lat64, 8);
        check("x16_results", i16, 2);
        check("x64_results", i64, 2);

        for (int i = 0; i < 100 && sb_q.size() > 0; i++) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
